// File: rtl/pid_integ_ss_pkg.sv
// Shared widths, rails and types for the balance PID state block.
// Also holds the saturating pitch-integrator add used by pid_integ_ss.
package pid_pkg;

  localparam int PTCH_W     = 16;
  localparam int INTEG_W    = 18;
  localparam int CNTRL_W    = 12;
  localparam int SS_SCALE_W = 8;

  typedef logic signed [PTCH_W-1:0]  ptch_t;
  typedef logic signed [INTEG_W-1:0] integ_t;
  typedef logic signed [CNTRL_W-1:0] cntrl_t;

  localparam integ_t INTEG_MAX = 18'h1FFFF;
  localparam integ_t INTEG_MIN = 18'h20000;

  // Two's-complement add that pins to a rail instead of wrapping sign.
  function automatic integ_t integ_sat_add(input integ_t acc, input ptch_t p);
    integ_t addend;
    integ_t sum;
    addend = {{(INTEG_W-PTCH_W){p[PTCH_W-1]}}, p};
    sum    = acc + addend;
    if (!acc[INTEG_W-1] && !addend[INTEG_W-1] && sum[INTEG_W-1]) begin
      return INTEG_MAX;
    end
    if (acc[INTEG_W-1] && addend[INTEG_W-1] && !sum[INTEG_W-1]) begin
      return INTEG_MIN;
    end
    return sum;
  endfunction

endpackage

// File: rtl/pid_integ_ss_soft_start_tmr.sv
// Soft-start ramp timer: counts up from clear, sticks at all-ones.
// The top byte is the authority scale applied to the PID output.
module soft_start_tmr
  import pid_pkg::*;
#(
  parameter int SS_W     = 27,
  parameter bit FAST_SIM = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic [SS_SCALE_W-1:0] ss_scale,
  output logic                  ss_full
);

  localparam logic [SS_W:0] INC = FAST_SIM ? (SS_W+1)'(256) : (SS_W+1)'(1);

  logic [SS_W-1:0] tmr_q;
  logic [SS_W-1:0] tmr_d;
  logic [SS_W:0]   tmr_sum;

  // Carry out of the widened add means the next step would wrap, so clamp.
  always_comb begin
    tmr_sum = {1'b0, tmr_q} + INC;
    tmr_d   = tmr_sum[SS_W] ? '1 : tmr_sum[SS_W-1:0];
    if (clr) begin
      tmr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end

  assign ss_scale = tmr_q[SS_W-1 -: SS_SCALE_W];
  assign ss_full  = (ss_scale == {SS_SCALE_W{1'b1}});

endmodule

// File: rtl/pid_integ_ss.sv
// Stateful front end of the balance PID: pitch integrator, soft-start
// timer and the registered, authority-scaled control output.
module pid_integ_ss
  import pid_pkg::*;
#(
  parameter int SS_W     = 27,
  parameter bit FAST_SIM = 1'b0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   vld,
  input  logic   rider_off,
  input  ptch_t  ptch,
  input  cntrl_t PID_cntrl,
  output integ_t integrator,
  output cntrl_t PID_ss,
  output logic   pid_vld
);

  integ_t integ_q, integ_d;
  logic   vld_dly_q, vld_dly_d;
  cntrl_t pid_ss_q, pid_ss_d;
  logic   pid_vld_q, pid_vld_d;

  logic [SS_SCALE_W-1:0] ss_scale;
  logic                  ss_full;
  logic signed [20:0]    prod;
  cntrl_t                scaled;

  soft_start_tmr #(
    .SS_W     (SS_W),
    .FAST_SIM (FAST_SIM)
  ) u_ss_tmr (
    .clk      (clk),
    .rst      (rst),
    .clr      (rider_off),
    .ss_scale (ss_scale),
    .ss_full  (ss_full)
  );

  // Scale is 0..254 out of 256, so the shifted product never exceeds PID_cntrl.
  always_comb begin
    prod   = 21'(PID_cntrl) * 21'($signed({1'b0, ss_scale}));
    scaled = CNTRL_W'(prod >>> 8);
  end

  always_comb begin
    integ_d   = integ_q;
    vld_dly_d = vld & ~rider_off;
    pid_ss_d  = pid_ss_q;
    pid_vld_d = vld_dly_q;
    if (rider_off) begin
      integ_d   = '0;
      pid_ss_d  = '0;
      pid_vld_d = 1'b0;
    end else begin
      if (vld) begin
        integ_d = integ_sat_add(integ_q, ptch);
      end
      if (vld_dly_q) begin
        pid_ss_d = ss_full ? PID_cntrl : scaled;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      integ_q   <= '0;
      vld_dly_q <= 1'b0;
      pid_ss_q  <= '0;
      pid_vld_q <= 1'b0;
    end else begin
      integ_q   <= integ_d;
      vld_dly_q <= vld_dly_d;
      pid_ss_q  <= pid_ss_d;
      pid_vld_q <= pid_vld_d;
    end
  end

  assign integrator = integ_q;
  assign PID_ss     = pid_ss_q;
  assign pid_vld    = pid_vld_q;

endmodule

// File: tb/tb_pid_integ_ss.sv
// Bench for pid_integ_ss: integrator rails, soft-start scaling, output timing.
// PID_cntrl is driven directly by the bench in place of PID_Math.
module tb_pid_integ_ss;

  localparam int NO_FIXED = 32'h7FFF_FFFF;

  logic               clk = 1'b0;
  logic               rst;
  logic               vld;
  logic               rider_off;
  logic signed [15:0] ptch;
  logic signed [11:0] PID_cntrl;
  logic signed [17:0] integrator;
  logic signed [11:0] PID_ss;
  logic               pid_vld;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;
  logic [15:0] mdl_tmr;
  logic [43:0] exp_q[$];

  pid_integ_ss #(
    .SS_W     (16),
    .FAST_SIM (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vld        (vld),
    .rider_off  (rider_off),
    .ptch       (ptch),
    .PID_cntrl  (PID_cntrl),
    .integrator (integrator),
    .PID_ss     (PID_ss),
    .pid_vld    (pid_vld)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference soft-start timer: +256 per clock, sticks at 16'hFFFF.
  always @(posedge clk or posedge rst) begin
    if (rst) mdl_tmr <= '0;
    else if (rider_off) mdl_tmr <= '0;
    else if (mdl_tmr > 16'hFEFF) mdl_tmr <= 16'hFFFF;
    else mdl_tmr <= mdl_tmr + 16'd256;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scale the DUT will use at the capture edge of a strobe driven now.
  function automatic logic [7:0] next_scale();
    logic [16:0] s;
    s = {1'b0, mdl_tmr} + 17'd256;
    return s[16] ? 8'hFF : s[15:8];
  endfunction

  function automatic logic [11:0] ss_model(input int c, input logic [7:0] s);
    int p;
    if (s == 8'hFF) return c[11:0];
    p = c * int'({24'd0, s});
    p = p >>> 8;
    return p[11:0];
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cntrl(input logic signed [11:0] v);
    idle(1);
    PID_cntrl = v;
  endtask

  // Called and returns at a negedge; back-to-back calls give back-to-back strobes.
  task automatic pulse(input logic [15:0] p, input logic roff, input logic [17:0] exp_integ,
                       input int exp_ss);
    logic [11:0] e;
    vld       = 1'b1;
    ptch      = p;
    rider_off = roff;
    if (!roff) begin
      e = (exp_ss == NO_FIXED) ? ss_model(int'(PID_cntrl), next_scale()) : exp_ss[11:0];
      exp_q.push_back({cyc + 32'd2, e});
    end
    @(negedge clk);
    vld       = 1'b0;
    rider_off = 1'b0;
    check_val("integ", {14'd0, integrator}, {14'd0, exp_integ});
  endtask

  task automatic clear_rider();
    rider_off = 1'b1;
    @(negedge clk);
    rider_off = 1'b0;
    check_val("integ_clr", {14'd0, integrator}, 32'd0);
  endtask

  task automatic wait_scale(input logic [7:0] s);
    int n;
    n = 0;
    while (next_scale() != s && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_val("wait_scale", {24'd0, next_scale()}, {24'd0, s});
  endtask

  always @(negedge clk) begin
    logic [43:0] e;
    if (!rst && pid_vld) begin
      if (exp_q.size() == 0) begin
        check_val("unexp_pid_vld", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("pid_vld_cyc", cyc, e[43:12]);
        check_val("pid_ss", {20'd0, PID_ss}, {20'd0, e[11:0]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    vld       = 1'b0;
    rider_off = 1'b0;
    ptch      = '0;
    PID_cntrl = 12'sd100;
    #1 rst = 1'b1;
    idle(3);
    check_val("rst_integ", {14'd0, integrator}, 32'd0);
    check_val("rst_pid_ss", {20'd0, PID_ss}, 32'd0);
    check_val("rst_pid_vld", {31'd0, pid_vld}, 32'd0);
    rst = 1'b0;
    idle(4);
    check_val("idle_pid_vld", {31'd0, pid_vld}, 32'd0);

    // Basic accumulation with spaced strobes.
    pulse(16'h0100, 1'b0, 18'h00100, NO_FIXED);
    idle(1);
    pulse(16'h0100, 1'b0, 18'h00200, NO_FIXED);
    idle(1);
    pulse(16'h0100, 1'b0, 18'h00300, NO_FIXED);
    idle(3);

    // Positive rail, back-to-back strobes.
    clear_rider();
    pulse(16'h7FFF, 1'b0, 18'h07FFF, NO_FIXED);
    pulse(16'h7FFF, 1'b0, 18'h0FFFE, NO_FIXED);
    pulse(16'h7FFF, 1'b0, 18'h17FFD, NO_FIXED);
    pulse(16'h7F83, 1'b0, 18'h1FF80, NO_FIXED);
    pulse(16'h0100, 1'b0, 18'h1FFFF, NO_FIXED);
    pulse(16'h0100, 1'b0, 18'h1FFFF, NO_FIXED);
    pulse(16'hFFFF, 1'b0, 18'h1FFFE, NO_FIXED);
    idle(3);

    // Negative rail.
    clear_rider();
    pulse(16'h8000, 1'b0, 18'h38000, NO_FIXED);
    pulse(16'h8000, 1'b0, 18'h30000, NO_FIXED);
    pulse(16'h8000, 1'b0, 18'h28000, NO_FIXED);
    pulse(16'h8010, 1'b0, 18'h20010, NO_FIXED);
    pulse(16'hFF00, 1'b0, 18'h20000, NO_FIXED);
    pulse(16'hFF00, 1'b0, 18'h20000, NO_FIXED);
    pulse(16'h0001, 1'b0, 18'h20001, NO_FIXED);
    idle(3);

    // Strobe coincident with rider_off, then ramp restarts from zero.
    set_cntrl(12'sd1024);
    clear_rider();
    pulse(16'h0100, 1'b0, 18'h00100, NO_FIXED);
    pulse(16'h0100, 1'b0, 18'h00200, NO_FIXED);
    pulse(16'h0100, 1'b0, 18'h00300, NO_FIXED);
    idle(2);
    pulse(16'h0100, 1'b1, 18'h00000, NO_FIXED);
    check_val("clr_pid_ss", {20'd0, PID_ss}, 32'd0);
    check_val("clr_pid_vld", {31'd0, pid_vld}, 32'd0);
    pulse(16'h0100, 1'b0, 18'h00100, 4);
    idle(2);

    // Soft-start mid-ramp, full scale, then full negative command.
    wait_scale(8'd128);
    pulse(16'h0000, 1'b0, 18'h00100, 512);
    wait_scale(8'hFF);
    pulse(16'h0000, 1'b0, 18'h00100, 1024);
    set_cntrl(-12'sd2048);
    pulse(16'h0000, 1'b0, 18'h00100, -2048);
    idle(3);

    // Reset while a strobe is in flight: no pid_vld may follow.
    vld  = 1'b1;
    ptch = 16'h0010;
    @(negedge clk);
    vld = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_integ", {14'd0, integrator}, 32'd0);
    check_val("mid_rst_pid_ss", {20'd0, PID_ss}, 32'd0);
    check_val("mid_rst_pid_vld", {31'd0, pid_vld}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(4);

    check_val("exp_q_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
